// File: rtl/word_byte_sequencer.sv
// rtl/word_byte_sequencer.sv - serializes 32-bit words into a 1-4 byte stream, LSB- or MSB-first
module word_byte_sequencer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [31:0] word_data,
   input  logic [1:0]  word_len,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [7:0]  byte_data,
   output logic        byte_last,
   output logic [1:0]  sel,
   output logic        busy
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  cnt;
   logic [31:0] word_reg;
   logic [1:0]  len_reg;
   logic        word_take;
   logic        byte_take;

   assign word_take = word_valid & word_ready;
   assign byte_take = byte_valid & byte_ready;

   // State register; reset abandons any word in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave SEND only when the final byte goes out with no word waiting
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (word_valid) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (byte_take && byte_last && !word_valid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: word_ready in SEND follows byte_ready on the last byte so words chain without a bubble
   always_comb begin
      word_ready = 1'b0;
      byte_valid = 1'b0;
      busy       = 1'b0;
      byte_last  = 1'b0;
      sel        = 2'd0;
      case (state)
         IDLE: begin
            word_ready = 1'b1;
         end
         SEND: begin
            byte_valid = 1'b1;
            busy       = 1'b1;
            byte_last  = (cnt == len_reg);
            sel        = MSB_FIRST ? (len_reg - cnt) : cnt;
            word_ready = byte_ready & byte_last;
         end
         default: ;
      endcase
   end

   // 4:1 byte-lane mux on the held word
   always_comb begin
      byte_data = 8'h00;
      case (sel)
         2'd0: byte_data = word_reg[7:0];
         2'd1: byte_data = word_reg[15:8];
         2'd2: byte_data = word_reg[23:16];
         2'd3: byte_data = word_reg[31:24];
         default: byte_data = 8'h00;
      endcase
   end

   // Word/length capture and byte counter; a new word always restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 2'd0;
         word_reg <= 32'd0;
         len_reg  <= 2'd0;
      end else if (word_take) begin
         cnt      <= 2'd0;
         word_reg <= word_data;
         len_reg  <= word_len;
      end else if (byte_take && !byte_last) begin
         cnt <= cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// tb/tb_word_byte_sequencer.sv - randomized and directed checks of both lane orders against a byte-queue model
module tb_word_byte_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        word_valid;
   logic [31:0] word_data;
   logic [1:0]  word_len;
   logic        byte_ready;

   logic        wr0, bv0, la0, bu0;
   logic [7:0]  d0;
   logic [1:0]  sel0;
   logic        wr1, bv1, la1, bu1;
   logic [7:0]  d1;
   logic [1:0]  sel1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic       last;
      logic [1:0] lane;
      logic [7:0] data;
   } ent_t;

   typedef struct packed {
      logic [31:0] w;
      logic [1:0]  len;
   } pend_t;

   ent_t  q0[$];
   ent_t  q1[$];
   pend_t pending[$];

   always #5 clk = ~clk;

   word_byte_sequencer #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst),
      .word_valid(word_valid), .word_ready(wr0), .word_data(word_data), .word_len(word_len),
      .byte_valid(bv0), .byte_ready(byte_ready), .byte_data(d0), .byte_last(la0),
      .sel(sel0), .busy(bu0)
   );

   word_byte_sequencer #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst),
      .word_valid(word_valid), .word_ready(wr1), .word_data(word_data), .word_len(word_len),
      .byte_valid(bv1), .byte_ready(byte_ready), .byte_data(d1), .byte_last(la1),
      .sel(sel1), .busy(bu1)
   );

   // Reference: each accepted word becomes a list of bytes in issue order; one leaves per byte handshake
   always @(posedge clk) begin : model
      logic       acc;
      pend_t      p;
      logic [1:0] lane;
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         acc = word_valid && (q0.size() == 0 || (byte_ready && q0[0].last));
         if (q0.size() != 0 && byte_ready) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (acc) begin
            p = pending.pop_front();
            for (int k = 0; k <= int'(p.len); k++) begin
               lane = 2'(k);
               q0.push_back('{last: (k == int'(p.len)), lane: lane, data: p.w[8*k +: 8]});
               lane = 2'(int'(p.len) - k);
               q1.push_back('{last: (k == int'(p.len)), lane: lane, data: p.w[8*(int'(p.len) - k) +: 8]});
            end
         end
      end
   end

   function automatic logic [27:0] obs();
      return {wr0, bv0, bu0, la0, wr1, bv1, bu1, la1, sel0, d0, sel1, d1};
   endfunction

   function automatic logic [27:0] expv();
      logic wr;
      if (q0.size() == 0) return 28'h8800000;
      wr = byte_ready & q0[0].last;
      return {wr, 1'b1, 1'b1, q0[0].last, wr, 1'b1, 1'b1, q1[0].last,
              q0[0].lane, q0[0].data, q1[0].lane, q1[0].data};
   endfunction

   function automatic logic [27:0] expm();
      return (q0.size() == 0) ? 28'hEE00000 : 28'hFFFFFFF;
   endfunction

   task automatic drive_word();
      word_valid = (pending.size() != 0);
      word_data  = (pending.size() != 0) ? pending[0].w : 32'h0;
      word_len   = (pending.size() != 0) ? pending[0].len : 2'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs() !== 28'h8800000) begin
         miscompares++;
         $display("FAIL reset: got %h want %h", obs(), 28'h8800000);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_words(input string name, input int n, input int stall_until);
      for (int i = 0; i < n; i++) begin
         drive_word();
         byte_ready = (i >= stall_until);
         @(negedge clk);
         vectors++;
         if (((obs() ^ expv()) & expm()) !== 28'h0) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got %h want %h mask %h", name, i, obs(), expv(), expm());
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_lsb_word();
      pending.push_back('{w: 32'hDDCCBBAA, len: 2'd3});
      test_words("four_byte_word", 7, 0);
   endtask

   task automatic test_msb_word();
      pending.push_back('{w: 32'h44332211, len: 2'd2});
      test_words("three_byte_word", 6, 0);
   endtask

   task automatic test_back_to_back();
      pending.push_back('{w: 32'h11223344, len: 2'd3});
      pending.push_back('{w: 32'h55667788, len: 2'd3});
      test_words("back_to_back", 11, 0);
   endtask

   task automatic test_backpressure();
      pending.push_back('{w: 32'hA5A50F0F, len: 2'd1});
      test_words("backpressure", 10, 6);
   endtask

   task automatic test_single_byte();
      pending.push_back('{w: 32'h000000E7, len: 2'd0});
      pending.push_back('{w: 32'h9C5A3B00, len: 2'd1});
      test_words("single_byte", 5, 0);
   endtask

   task automatic test_reset_mid_word();
      bit found = 1'b0;
      pending.push_back('{w: 32'hCAFEBABE, len: 2'd3});
      for (int i = 0; i < 10; i++) begin
         drive_word();
         byte_ready = 1'b1;
         if (q0.size() != 0 && q0[0].lane == 2'd2) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL reset_mid_word: lane 2 reached=%0d want 1", found);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive_word();
      @(negedge clk);
      vectors++;
      if (obs() !== 28'h8800000) begin
         miscompares++;
         $display("FAIL reset_mid_word_after: got %h want %h", obs(), 28'h8800000);
      end
      @(posedge clk);
      #1;
      pending.push_back('{w: 32'h01020304, len: 2'd3});
      test_words("after_reset_word", 7, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && pending.size() < 3)
            pending.push_back('{w: $urandom, len: 2'($urandom_range(0, 3))});
         drive_word();
         byte_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         vectors++;
         if (((obs() ^ expv()) & expm()) !== 28'h0) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h want %h mask %h", i, obs(), expv(), expm());
         end
         @(posedge clk);
         #1;
      end
      test_words("random_drain", 30, 0);
      vectors++;
      if (q0.size() != 0 || pending.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain_empty: left %0d bytes %0d words want 0", q0.size(), pending.size());
      end
   endtask

   initial begin
      rst        = 1'b1;
      word_valid = 1'b0;
      word_data  = 32'h0;
      word_len   = 2'd0;
      byte_ready = 1'b0;
      test_reset();
      test_lsb_word();
      test_msb_word();
      test_back_to_back();
      test_backpressure();
      test_single_byte();
      test_reset_mid_word();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
